// File: rtl/spi_synth_pkg.sv
// Shared constants and parser state encoding for the SPI-fed MIDI front end.
package spi_synth_pkg;

  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_CC       = 4'hB;

  // Status bytes at or above this value are real-time and never touch framing.
  localparam logic [7:0] RT_THRESH = 8'hF8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_D1,
    WAIT_D2
  } parser_state_e;

  function automatic logic is_channel_type(input logic [3:0] t);
    return (t == ST_NOTE_OFF) || (t == ST_NOTE_ON) || (t == ST_CC);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: one-cycle pulse on each low-to-high transition of i_sig.
module rise_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_rise
);

  logic r_sig_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sig_d <= 1'b0;
    end else begin
      r_sig_d <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_sig_d;

endmodule

// File: rtl/spi_midi_parser.sv
// Frames SPI-received bytes into note-on/off and control-change events with running status,
// channel filtering, real-time passthrough and inter-byte timeout resync.
module spi_midi_parser
  import spi_synth_pkg::*;
#(
  parameter logic [3:0]        P_CHANNEL = 4'd0,
  parameter int unsigned       P_TO_W    = 24,
  parameter logic [P_TO_W-1:0] P_TIMEOUT = 24'd1_000_000
) (
  input  logic       i_sys_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_data_load,
  output logic       o_note_on,
  output logic       o_note_off,
  output logic [6:0] o_note,
  output logic [6:0] o_velocity,
  output logic       o_cc_valid,
  output logic [6:0] o_cc_num,
  output logic [6:0] o_cc_val,
  output logic       o_error
);

  localparam logic [P_TO_W-1:0] L_TO_LAST = P_TIMEOUT - 1'b1;

  logic w_acc;
  logic w_byte;

  parser_state_e     r_state;
  logic              r_rs_valid;
  logic [3:0]        r_rs_type;
  logic [3:0]        r_rs_chan;
  logic [6:0]        r_d1;
  logic [P_TO_W-1:0] r_to_cnt;
  logic              r_note_on;
  logic              r_note_off;
  logic [6:0]        r_note;
  logic [6:0]        r_velocity;
  logic              r_cc_valid;
  logic [6:0]        r_cc_num;
  logic [6:0]        r_cc_val;
  logic              r_error;

  rise_detect u_rise_detect (
    .i_clk   (i_sys_clk),
    .i_rst_n (i_rst_n),
    .i_sig   (i_data_load),
    .o_rise  (w_acc)
  );

  // Real-time bytes are invisible to framing and to the timeout counter.
  assign w_byte = w_acc & (i_data < RT_THRESH);

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_rs_valid <= 1'b0;
      r_rs_type  <= 4'h0;
      r_rs_chan  <= 4'h0;
      r_d1       <= 7'h00;
      r_to_cnt   <= '0;
      r_note_on  <= 1'b0;
      r_note_off <= 1'b0;
      r_note     <= 7'h00;
      r_velocity <= 7'h00;
      r_cc_valid <= 1'b0;
      r_cc_num   <= 7'h00;
      r_cc_val   <= 7'h00;
      r_error    <= 1'b0;
    end else begin
      r_note_on  <= 1'b0;
      r_note_off <= 1'b0;
      r_cc_valid <= 1'b0;
      r_error    <= 1'b0;
      if (w_byte) begin
        r_to_cnt <= '0;
        if (i_data[7]) begin
          if (is_channel_type(i_data[7:4])) begin
            r_rs_valid <= 1'b1;
            r_rs_type  <= i_data[7:4];
            r_rs_chan  <= i_data[3:0];
            r_d1       <= 7'h00;
            r_state    <= WAIT_D1;
          end else begin
            r_rs_valid <= 1'b0;
            r_state    <= IDLE;
          end
        end else begin
          case (r_state)
            IDLE: begin
              if (r_rs_valid) begin
                r_d1    <= i_data[6:0];
                r_state <= WAIT_D2;
              end else begin
                r_error <= 1'b1;
              end
            end
            WAIT_D1: begin
              r_d1    <= i_data[6:0];
              r_state <= WAIT_D2;
            end
            WAIT_D2: begin
              r_state <= IDLE;
              if (r_rs_chan == P_CHANNEL) begin
                case (r_rs_type)
                  ST_NOTE_ON, ST_NOTE_OFF: begin
                    r_note     <= r_d1;
                    r_velocity <= i_data[6:0];
                    if (r_rs_type == ST_NOTE_ON && i_data[6:0] != 7'h00) begin
                      r_note_on <= 1'b1;
                    end else begin
                      r_note_off <= 1'b1;
                    end
                  end
                  ST_CC: begin
                    r_cc_num   <= r_d1;
                    r_cc_val   <= i_data[6:0];
                    r_cc_valid <= 1'b1;
                  end
                  default: ;
                endcase
              end
            end
            default: r_state <= IDLE;
          endcase
        end
      end else if (r_state != IDLE) begin
        // Abort a stalled partial message but keep running status for resync.
        if (r_to_cnt == L_TO_LAST) begin
          r_state  <= IDLE;
          r_error  <= 1'b1;
          r_to_cnt <= '0;
        end else if (r_to_cnt != '1) begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign o_note_on  = r_note_on;
  assign o_note_off = r_note_off;
  assign o_note     = r_note;
  assign o_velocity = r_velocity;
  assign o_cc_valid = r_cc_valid;
  assign o_cc_num   = r_cc_num;
  assign o_cc_val   = r_cc_val;
  assign o_error    = r_error;

endmodule

// File: tb/tb_spi_midi_parser.sv
// Self-checking bench: directed vector table, hand sequences for timeout/reset, and a
// randomized byte stream checked against a queue-based message model.
module tb_spi_midi_parser;

  localparam logic [3:0] EV_NONE = 4'b0000;
  localparam logic [3:0] EV_ON   = 4'b1000;
  localparam logic [3:0] EV_OFF  = 4'b0100;
  localparam logic [3:0] EV_CC   = 4'b0010;
  localparam logic [3:0] EV_ERR  = 4'b0001;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       load  = 1'b0;

  logic       on_a, off_a, cc_a, err_a;
  logic [6:0] note_a, vel_a, ccn_a, ccv_a;
  logic       on_b, off_b, cc_b, err_b;
  logic [6:0] note_b, vel_b, ccn_b, ccv_b;

  always #5 clk = ~clk;

  spi_midi_parser #(
    .P_CHANNEL (4'd0),
    .P_TO_W    (24),
    .P_TIMEOUT (24'd64)
  ) u_dut (
    .i_sys_clk   (clk),
    .i_rst_n     (rst_n),
    .i_data      (data),
    .i_data_load (load),
    .o_note_on   (on_a),
    .o_note_off  (off_a),
    .o_note      (note_a),
    .o_velocity  (vel_a),
    .o_cc_valid  (cc_a),
    .o_cc_num    (ccn_a),
    .o_cc_val    (ccv_a),
    .o_error     (err_a)
  );

  // Short-timeout instance, only checked in the timeout sequence.
  spi_midi_parser #(
    .P_CHANNEL (4'd0),
    .P_TO_W    (24),
    .P_TIMEOUT (24'd16)
  ) u_dut_to (
    .i_sys_clk   (clk),
    .i_rst_n     (rst_n),
    .i_data      (data),
    .i_data_load (load),
    .o_note_on   (on_b),
    .o_note_off  (off_b),
    .o_note      (note_b),
    .o_velocity  (vel_b),
    .o_cc_valid  (cc_b),
    .o_cc_num    (ccn_b),
    .o_cc_val    (ccv_b),
    .o_error     (err_b)
  );

  int n_pass = 0;
  int n_chk  = 0;

  function automatic logic [3:0] ev_a();
    return {on_a, off_a, cc_a, err_a};
  endfunction

  function automatic logic [3:0] ev_b();
    return {on_b, off_b, cc_b, err_b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic chk_fields(input string tag, input logic [6:0] n, input logic [6:0] v,
                            input logic [6:0] cn, input logic [6:0] cv);
    chk({tag, " note"}, 32'(note_a), 32'(n));
    chk({tag, " velocity"}, 32'(vel_a), 32'(v));
    chk({tag, " cc_num"}, 32'(ccn_a), 32'(cn));
    chk({tag, " cc_val"}, 32'(ccv_a), 32'(cv));
  endtask

  // Presents one byte for `hold` cycles then drops the level for `gap` cycles.
  // f* = pulses in the cycle after the accept edge, l* = any pulses afterwards.
  task automatic send(input logic [7:0] b, input int hold, input int gap,
                      output logic [3:0] fa, output logic [3:0] la,
                      output logic [3:0] fb, output logic [3:0] lb);
    @(negedge clk);
    data = b;
    load = 1'b1;
    @(posedge clk);
    #1;
    fa = ev_a();
    fb = ev_b();
    la = EV_NONE;
    lb = EV_NONE;
    for (int i = 1; i < hold; i++) begin
      @(posedge clk);
      #1;
      la |= ev_a();
      lb |= ev_b();
    end
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk);
      #1;
      la |= ev_a();
      lb |= ev_b();
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    load  = 1'b0;
    data  = 8'h00;
    #1;
    chk({tag, " rst events"}, 32'(ev_a()), 32'(EV_NONE));
    chk_fields({tag, " rst"}, 7'h00, 7'h00, 7'h00, 7'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] b;
    int         hold;
    logic [3:0] ev;
    logic [6:0] note, vel, ccn, ccv;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] b, input int hold, input logic [3:0] ev,
                              input logic [6:0] n, input logic [6:0] v,
                              input logic [6:0] cn, input logic [6:0] cv);
    vec_t r;
    r.b = b; r.hold = hold; r.ev = ev; r.note = n; r.vel = v; r.ccn = cn; r.ccv = cv;
    return r;
  endfunction

  // Reference model: collects data bytes of the current message in a queue.
  logic       m_rs_valid;
  logic [3:0] m_type, m_chan;
  logic [6:0] m_buf[$];
  bit         m_active;
  logic [6:0] m_note, m_vel, m_ccn, m_ccv;

  task automatic model_reset();
    m_rs_valid = 1'b0; m_type = 4'h0; m_chan = 4'h0; m_active = 1'b0;
    m_buf.delete();
    m_note = 7'h00; m_vel = 7'h00; m_ccn = 7'h00; m_ccv = 7'h00;
  endtask

  task automatic model_byte(input logic [7:0] b, output logic [3:0] ev);
    ev = EV_NONE;
    if (b >= 8'hF8) return;
    if (b[7]) begin
      m_buf.delete();
      if (b[7:4] == 4'h8 || b[7:4] == 4'h9 || b[7:4] == 4'hB) begin
        m_rs_valid = 1'b1; m_type = b[7:4]; m_chan = b[3:0]; m_active = 1'b1;
      end else begin
        m_rs_valid = 1'b0; m_active = 1'b0;
      end
      return;
    end
    if (!m_active && !m_rs_valid) begin
      ev = EV_ERR;
      return;
    end
    m_active = 1'b1;
    m_buf.push_back(b[6:0]);
    if (m_buf.size() == 2) begin
      m_active = 1'b0;
      if (m_chan == 4'd0) begin
        if (m_type == 4'hB) begin
          ev = EV_CC; m_ccn = m_buf[0]; m_ccv = m_buf[1];
        end else begin
          ev = (m_type == 4'h9 && m_buf[1] != 7'h00) ? EV_ON : EV_OFF;
          m_note = m_buf[0]; m_vel = m_buf[1];
        end
      end
      m_buf.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[$];
    logic [3:0] fa, la, fb, lb, mev;
    logic [7:0] b;
    bit         prev_rt;
    int         k_err;
    logic [3:0] seen;

    vecs.push_back(mk(8'h90,  1, EV_NONE, 7'h00, 7'h00, 7'h00, 7'h00));
    vecs.push_back(mk(8'h3C,  1, EV_NONE, 7'h00, 7'h00, 7'h00, 7'h00));
    vecs.push_back(mk(8'h64,  1, EV_ON,   7'h3C, 7'h64, 7'h00, 7'h00));
    vecs.push_back(mk(8'h90,  1, EV_NONE, 7'h3C, 7'h64, 7'h00, 7'h00));
    vecs.push_back(mk(8'h40,  2, EV_NONE, 7'h3C, 7'h64, 7'h00, 7'h00));
    vecs.push_back(mk(8'h50,  1, EV_ON,   7'h40, 7'h50, 7'h00, 7'h00));
    vecs.push_back(mk(8'h43,  1, EV_NONE, 7'h40, 7'h50, 7'h00, 7'h00));
    vecs.push_back(mk(8'h00,  1, EV_OFF,  7'h43, 7'h00, 7'h00, 7'h00));
    vecs.push_back(mk(8'hB0, 20, EV_NONE, 7'h43, 7'h00, 7'h00, 7'h00));
    vecs.push_back(mk(8'h07, 20, EV_NONE, 7'h43, 7'h00, 7'h00, 7'h00));
    vecs.push_back(mk(8'h7F, 20, EV_CC,   7'h43, 7'h00, 7'h07, 7'h7F));
    vecs.push_back(mk(8'h91,  1, EV_NONE, 7'h43, 7'h00, 7'h07, 7'h7F));
    vecs.push_back(mk(8'h3C,  1, EV_NONE, 7'h43, 7'h00, 7'h07, 7'h7F));
    vecs.push_back(mk(8'h64,  1, EV_NONE, 7'h43, 7'h00, 7'h07, 7'h7F));
    vecs.push_back(mk(8'h80,  1, EV_NONE, 7'h43, 7'h00, 7'h07, 7'h7F));
    vecs.push_back(mk(8'h3C,  1, EV_NONE, 7'h43, 7'h00, 7'h07, 7'h7F));
    vecs.push_back(mk(8'h10,  1, EV_OFF,  7'h3C, 7'h10, 7'h07, 7'h7F));
    vecs.push_back(mk(8'h90,  1, EV_NONE, 7'h3C, 7'h10, 7'h07, 7'h7F));
    vecs.push_back(mk(8'h3C,  1, EV_NONE, 7'h3C, 7'h10, 7'h07, 7'h7F));
    vecs.push_back(mk(8'hF8,  1, EV_NONE, 7'h3C, 7'h10, 7'h07, 7'h7F));
    vecs.push_back(mk(8'h64,  1, EV_ON,   7'h3C, 7'h64, 7'h07, 7'h7F));
    vecs.push_back(mk(8'hF0,  1, EV_NONE, 7'h3C, 7'h64, 7'h07, 7'h7F));
    vecs.push_back(mk(8'h22,  1, EV_ERR,  7'h3C, 7'h64, 7'h07, 7'h7F));
    vecs.push_back(mk(8'h5A,  1, EV_ERR,  7'h3C, 7'h64, 7'h07, 7'h7F));

    repeat (2) @(negedge clk);
    do_reset("init");

    foreach (vecs[i]) begin
      send(vecs[i].b, vecs[i].hold, 2, fa, la, fb, lb);
      chk($sformatf("vec%0d event", i), 32'(fa), 32'(vecs[i].ev));
      chk($sformatf("vec%0d stray", i), 32'(la), 32'(EV_NONE));
      chk_fields($sformatf("vec%0d", i), vecs[i].note, vecs[i].vel, vecs[i].ccn, vecs[i].ccv);
    end

    // Lone data byte straight after reset.
    do_reset("lone");
    send(8'h22, 1, 2, fa, la, fb, lb);
    chk("lone event", 32'(fa), 32'(EV_ERR));
    chk_fields("lone", 7'h00, 7'h00, 7'h00, 7'h00);

    // Timeout on the 16-cycle instance, then running-status resync.
    do_reset("tmo");
    send(8'h90, 1, 1, fa, la, fb, lb);
    send(8'h3C, 1, 0, fa, la, fb, lb);
    chk("tmo d1 event", 32'(fb), 32'(EV_NONE));
    k_err = -1;
    seen  = EV_NONE;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (ev_b() != EV_NONE && k_err < 0) begin
        k_err = k;
        seen  = ev_b();
      end
    end
    chk("tmo cycle", 32'(k_err), 32'd16);
    chk("tmo event", 32'(seen), 32'(EV_ERR));
    send(8'h45, 1, 2, fa, la, fb, lb);
    chk("tmo rs d1 event", 32'(fb), 32'(EV_NONE));
    send(8'h01, 1, 2, fa, la, fb, lb);
    chk("tmo rs event", 32'(fb), 32'(EV_ON));
    chk("tmo rs note", 32'(note_b), 32'h45);
    chk("tmo rs velocity", 32'(vel_b), 32'h01);

    // Reset in the middle of a message discards it and clears running status.
    do_reset("mid");
    send(8'h90, 1, 2, fa, la, fb, lb);
    send(8'h3C, 1, 2, fa, la, fb, lb);
    send(8'h64, 1, 2, fa, la, fb, lb);
    chk("mid first event", 32'(fa), 32'(EV_ON));
    send(8'h90, 1, 2, fa, la, fb, lb);
    send(8'h3C, 1, 2, fa, la, fb, lb);
    do_reset("mid2");
    send(8'h64, 1, 2, fa, la, fb, lb);
    chk("mid after reset event", 32'(fa), 32'(EV_ERR));
    chk("mid after reset stray", 32'(la), 32'(EV_NONE));
    chk_fields("mid after reset", 7'h00, 7'h00, 7'h00, 7'h00);

    // Randomized stream against the model; gaps stay far below the 64-cycle timeout.
    do_reset("rand");
    model_reset();
    prev_rt = 1'b0;
    for (int n = 0; n < 300; n++) begin
      int r;
      int t;
      r = $urandom_range(0, 99);
      if (r < 10 && !prev_rt) begin
        b = 8'hF8 + 8'($urandom_range(0, 7));
      end else if (r < 35) begin
        t = $urandom_range(0, 9);
        if (t < 3)       b = 8'h80;
        else if (t < 6)  b = 8'h90;
        else if (t < 8)  b = 8'hB0;
        else if (t == 8) b = 8'hA0 + 8'(16 * $urandom_range(0, 3));
        else             b = 8'hF0 + 8'($urandom_range(0, 7));
        if (b < 8'hF0 && $urandom_range(0, 3) == 0) b = b | 8'h01;
      end else begin
        b = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(0, 127));
      end
      prev_rt = (b >= 8'hF8);
      send(b, $urandom_range(1, 3), $urandom_range(1, 3), fa, la, fb, lb);
      model_byte(b, mev);
      chk($sformatf("rand%0d byte %0h event", n, b), 32'(fa), 32'(mev));
      chk($sformatf("rand%0d stray", n), 32'(la), 32'(EV_NONE));
      chk_fields($sformatf("rand%0d", n), m_note, m_vel, m_ccn, m_ccv);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
